// File: rtl/exec_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// exec_ctrl_pkg
// Shared definitions for the exec_ctrl sequencer and its register file.
// Contents:
//   - instruction field layout (instr_t), opcode/op encodings
//   - shift codes and ALU operation codes
//   - FSM state enum and decoded instruction class enum
//   - small decode helpers
// ----------------------------------------------------------------------------
package exec_ctrl_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned REG_AW  = 3;
    localparam int unsigned FLAG_W  = 3;

    // Opcode field [15:13]
    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [2:0] OPC_MOV = 3'b110;

    // Op field [12:11] under OPC_MOV
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;

    // Op field [12:11] under OPC_ALU
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_CMP = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MVN = 2'b11;

    // Shift codes applied to the B operand
    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL1 = 2'b01;
    localparam logic [1:0] SH_LSR1 = 2'b10;
    localparam logic [1:0] SH_ASR1 = 2'b11;

    // ALU operation codes driven on alu_op
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    // Instruction word; imm8 overlays rd/shift/rm in bits [7:0]
    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] op;
        logic [2:0] rn;
        logic [2:0] rd;
        logic [1:0] shift;
        logic [2:0] rm;
    } instr_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_LOAD_A = 3'd2,
        ST_LOAD_B = 3'd3,
        ST_EXEC   = 3'd4,
        ST_WRITE  = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CLS_MOVI = 2'd0,
        CLS_MOVR = 2'd1,
        CLS_ALU  = 2'd2,
        CLS_ILL  = 2'd3
    } cls_t;

    // Classify an instruction into the sequencing path it takes
    function automatic cls_t decode_cls(input instr_t ir);
        cls_t cls;
        cls = CLS_ILL;
        if (ir.opcode == OPC_MOV && ir.op == OP_MOV_IMM) begin
            cls = CLS_MOVI;
        end else if (ir.opcode == OPC_MOV && ir.op == OP_MOV_REG) begin
            cls = CLS_MOVR;
        end else if (ir.opcode == OPC_ALU) begin
            cls = CLS_ALU;
        end
        return cls;
    endfunction

    // Map an ALU-class op field onto the ALU operation code
    function automatic logic [1:0] alu_op_of(input logic [1:0] op);
        logic [1:0] res;
        case (op)
            OP_ADD:  res = ALU_ADD;
            OP_CMP:  res = ALU_SUB;
            OP_AND:  res = ALU_AND;
            OP_MVN:  res = ALU_NOT;
            default: res = ALU_ADD;
        endcase
        return res;
    endfunction

    function automatic logic [7:0] get_imm8(input instr_t ir);
        return {ir.rd, ir.shift, ir.rm};
    endfunction

endpackage

// File: rtl/exec_regfile.sv
// ----------------------------------------------------------------------------
// exec_regfile
// NREG x DATA_W register file: one synchronous write port and two
// combinational read ports (operand and debug). Cleared by async reset.
// NREG is expected to match the 3-bit register address space (8 entries).
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_we/i_waddr/i_wdata    write port, takes effect at the rising edge
//   i_raddr -> o_rdata      operand read port
//   i_dbg_addr -> o_dbg_data debug read port
// ----------------------------------------------------------------------------
module exec_regfile
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata,
    input  logic [REG_AW-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);

    logic [DATA_W-1:0] r_mem [NREG];

    // Write port; reset clears every entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem <= '{default: '0};
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Combinational read ports
    assign o_rdata    = r_mem[i_raddr];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/exec_ctrl.sv
// ----------------------------------------------------------------------------
// exec_ctrl
// Multi-cycle instruction sequencer driving an external ALU. Accepts one
// 16-bit instruction at a time, loads operands from the register file,
// runs the ALU and writes the result back.
//   MOV-imm : IDLE -> DECODE -> WRITE                       (2 cycles)
//   MOV-reg : IDLE -> DECODE -> LOAD_B -> EXEC -> WRITE     (4 cycles)
//   ALU     : IDLE -> DECODE -> LOAD_A -> LOAD_B -> EXEC -> WRITE (5 cycles)
// Build option:
//   EXEC_CTRL_ILLEGAL_TRAP_EN  defined  : illegal opcode -> sticky illegal,
//                                         HALT until reset, no done
//                              undefined: illegal opcode retires as a NOP
// Ports:
//   clk, reset_n               clock, async active-low reset
//   in_valid/in_ready/instr    instruction handshake
//   alu_ain/alu_bin/alu_op     ALU operands and operation
//   alu_out/alu_z              ALU result and flags {ovf, neg, zero}
//   status                     flags latched by CMP
//   done                       one-cycle retire pulse
//   illegal                    sticky illegal-opcode flag (trap build)
//   dbg_addr/dbg_data          combinational debug register read
// ----------------------------------------------------------------------------
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [DATA_W-1:0]  alu_ain,
    output logic [DATA_W-1:0]  alu_bin,
    output logic [1:0]         alu_op,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic [FLAG_W-1:0]  alu_z,
    output logic [FLAG_W-1:0]  status,
    output logic               done,
    output logic               illegal,
    input  logic [REG_AW-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    state_t             r_state;
    instr_t             r_ir;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic [DATA_W-1:0]  r_c;
    logic [FLAG_W-1:0]  r_status;
    logic               r_done;
    logic               r_illegal;
    logic               r_in_ready;

    cls_t               w_cls;
    logic               w_we;
    logic [REG_AW-1:0]  w_waddr;
    logic [DATA_W-1:0]  w_wdata;
    logic [REG_AW-1:0]  w_raddr;
    logic [DATA_W-1:0]  w_rdata;
    logic [DATA_W-1:0]  w_imm_sx;

    // Operand shifter for the B path
    function automatic logic [DATA_W-1:0] shift_val(input logic [DATA_W-1:0] v,
                                                    input logic [1:0]        sh);
        logic [DATA_W-1:0] res;
        case (sh)
            SH_LSL1: res = {v[DATA_W-2:0], 1'b0};
            SH_LSR1: res = {1'b0, v[DATA_W-1:1]};
            SH_ASR1: res = {v[DATA_W-1], v[DATA_W-1:1]};
            default: res = v;
        endcase
        return res;
    endfunction

    // Class of the latched instruction steers every later state
    assign w_cls    = decode_cls(r_ir);
    assign w_imm_sx = DATA_W'($signed(get_imm8(r_ir)));

    // LOAD_A reads Rn, every other state presents Rm
    assign w_raddr = (r_state == ST_LOAD_A) ? r_ir.rn : r_ir.rm;

    // Write-back in WRITE; CMP and illegal NOPs leave the file untouched
    assign w_we    = (r_state == ST_WRITE) &&
                     ((w_cls == CLS_MOVI) || (w_cls == CLS_MOVR) ||
                      ((w_cls == CLS_ALU) && (r_ir.op != OP_CMP)));
    assign w_waddr = (w_cls == CLS_MOVI) ? r_ir.rn : r_ir.rd;
    assign w_wdata = (w_cls == CLS_MOVI) ? w_imm_sx : r_c;

    exec_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .i_clk      (clk),
        .i_rst_n    (reset_n),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata),
        .i_raddr    (w_raddr),
        .o_rdata    (w_rdata),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    // Sequencer: state, operand latches, result latch, flags and pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_ir       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_status   <= '0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_ir       <= instr_t'(instr);
                        r_in_ready <= 1'b0;
                        r_state    <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (w_cls)
                        CLS_MOVI: begin
                            r_done  <= 1'b1;
                            r_state <= ST_WRITE;
                        end
                        CLS_MOVR: r_state <= ST_LOAD_B;
                        CLS_ALU:  r_state <= ST_LOAD_A;
                        default: begin
`ifdef EXEC_CTRL_ILLEGAL_TRAP_EN
                            r_illegal <= 1'b1;
                            r_state   <= ST_HALT;
`else
                            r_done    <= 1'b1;
                            r_state   <= ST_WRITE;
`endif
                        end
                    endcase
                end
                ST_LOAD_A: begin
                    r_a     <= w_rdata;
                    r_state <= ST_LOAD_B;
                end
                ST_LOAD_B: begin
                    r_b     <= w_rdata;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_c <= alu_out;
                    if (w_cls == CLS_ALU && r_ir.op == OP_CMP) begin
                        r_status <= alu_z;
                    end
                    r_done  <= 1'b1;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // ALU operands derive from latched registers only, so they hold steady
    // outside EXEC; MOV-reg passes sh(B) through as 0 + sh(B)
    assign alu_ain = (w_cls == CLS_MOVR) ? '0 : r_a;
    assign alu_bin = shift_val(r_b, r_ir.shift);
    assign alu_op  = (w_cls == CLS_MOVR) ? ALU_ADD : alu_op_of(r_ir.op);

    assign in_ready = r_in_ready;
    assign status   = r_status;
    assign done     = r_done;
    assign illegal  = r_illegal;

endmodule

// File: tb/tb_exec_ctrl.sv
// ----------------------------------------------------------------------------
// tb_exec_ctrl
// Self-checking bench for exec_ctrl: directed cases with literal results,
// a reset-abort case, an illegal-opcode case, then randomized instruction
// streams compared against an architectural model (register array + status).
// The external ALU is modelled behaviourally.
// ----------------------------------------------------------------------------
module tb_exec_ctrl;

    localparam int unsigned DW = 16;

    logic          clk;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   instr;
    logic [DW-1:0] alu_ain;
    logic [DW-1:0] alu_bin;
    logic [1:0]    alu_op;
    logic [DW-1:0] alu_out;
    logic [2:0]    alu_z;
    logic [2:0]    status;
    logic          done;
    logic          illegal;
    logic [2:0]    dbg_addr;
    logic [DW-1:0] dbg_data;

    int n_checks = 0;
    int n_errors = 0;

    // Architectural model
    logic [15:0] m_reg [8];
    logic [2:0]  m_status;

    exec_ctrl #(.DATA_W(DW), .NREG(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .alu_ain  (alu_ain),
        .alu_bin  (alu_bin),
        .alu_op   (alu_op),
        .alu_out  (alu_out),
        .alu_z    (alu_z),
        .status   (status),
        .done     (done),
        .illegal  (illegal),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // External ALU
    logic [DW-1:0] env_res;
    logic          env_v;
    always_comb begin
        env_res = '0;
        env_v   = 1'b0;
        case (alu_op)
            2'b00: begin
                env_res = alu_ain + alu_bin;
                env_v   = (alu_ain[15] == alu_bin[15]) && (env_res[15] != alu_ain[15]);
            end
            2'b01: begin
                env_res = alu_ain - alu_bin;
                env_v   = (alu_ain[15] != alu_bin[15]) && (env_res[15] != alu_ain[15]);
            end
            2'b10:   env_res = alu_ain & alu_bin;
            default: env_res = ~alu_bin;
        endcase
    end
    assign alu_out = env_res;
    assign alu_z   = {env_v, env_res[15], (env_res == '0)};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] shv(input logic [15:0] v, input logic [1:0] s);
        case (s)
            2'd0:    return v;
            2'd1:    return v << 1;
            2'd2:    return v >> 1;
            default: return 16'($signed(v) >>> 1);
        endcase
    endfunction

    function automatic logic [15:0] f_movi(input logic [2:0] rn, input logic [7:0] imm);
        return {3'b110, 2'b10, rn, imm};
    endfunction

    function automatic logic [15:0] f_movr(input logic [2:0] rd, input logic [1:0] sh,
                                           input logic [2:0] rm);
        return {3'b110, 2'b00, 3'b000, rd, sh, rm};
    endfunction

    function automatic logic [15:0] f_alu(input logic [1:0] op, input logic [2:0] rn,
                                          input logic [2:0] rd, input logic [1:0] sh,
                                          input logic [2:0] rm);
        return {3'b101, op, rn, rd, sh, rm};
    endfunction

    function automatic logic [15:0] rand_instr();
        int          k;
        logic [15:0] w;
        k = $urandom_range(0, 9);
        w = 16'($urandom);
        if (k < 3)      w[15:11] = 5'b11010;
        else if (k < 4) w[15:11] = 5'b11000;
        else if (k < 9) w[15:13] = 3'b101;
`ifdef EXEC_CTRL_ILLEGAL_TRAP_EN
        else            w[15:11] = 5'b10100;
`endif
        return w;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 8; r++) m_reg[r] = '0;
        m_status = '0;
    endtask

    // Sweep all registers through the debug port, then status and illegal
    task automatic check_state(input string tag);
        for (int r = 0; r < 8; r++) begin
            dbg_addr = 3'(r);
            #1;
            check($sformatf("%s R%0d", tag, r), 32'(dbg_data), 32'(m_reg[r]));
        end
        check({tag, " status"}, 32'(status), 32'(m_status));
        check({tag, " illegal"}, 32'(illegal), 32'd0);
    endtask

    task automatic lit_reg(input string name, input logic [2:0] r, input logic [15:0] exp);
        @(negedge clk);
        dbg_addr = r;
        #1;
        check(name, 32'(dbg_data), 32'(exp));
    endtask

    task automatic wait_ready();
        int waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_wait", 32'(in_ready), 32'd1);
    endtask

    // Issue one instruction, hold in_valid while busy, check every cycle
    task automatic run_instr(input logic [15:0] ins);
        logic [2:0]  opc, rn, rd, rm;
        logic [1:0]  op, sh, e_op;
        logic [15:0] a, b, wdata, dd;
        logic [2:0]  waddr, nstat;
        int          lat, d;
        bit          wr, ill;
        opc = ins[15:13]; op = ins[12:11]; rn = ins[10:8];
        rd  = ins[7:5];   sh = ins[4:3];   rm = ins[2:0];
        a = m_reg[rn]; b = shv(m_reg[rm], sh);
        wr = 1'b0; ill = 1'b0; nstat = m_status; waddr = rd; wdata = '0;
        lat = 2; e_op = op;
        if (opc == 3'b110 && op == 2'b10) begin
            wr = 1'b1; waddr = rn; wdata = 16'($signed(ins[7:0]));
        end else if (opc == 3'b110 && op == 2'b00) begin
            lat = 4; wr = 1'b1; a = '0; wdata = b; e_op = 2'b00;
        end else if (opc == 3'b101) begin
            lat = 5;
            case (op)
                2'd0: begin wr = 1'b1; wdata = a + b; end
                2'd1: begin
                    d     = int'($signed(a)) - int'($signed(b));
                    dd    = 16'(d);
                    nstat = {(d > 32767 || d < -32768), dd[15], (dd == 16'd0)};
                end
                2'd2:    begin wr = 1'b1; wdata = a & b; end
                default: begin wr = 1'b1; wdata = ~b; end
            endcase
        end else begin
            ill = 1'b1;
        end

        wait_ready();
        in_valid = 1'b1;
        instr    = ins;
        @(negedge clk);
        instr = 16'($urandom);
`ifdef EXEC_CTRL_ILLEGAL_TRAP_EN
        if (ill) begin
            for (int c = 1; c <= 8; c++) begin
                if (c > 1) @(negedge clk);
                check("halt done", 32'(done), 32'd0);
                check("halt in_ready", 32'(in_ready), 32'd0);
                if (c >= 2) check("halt illegal", 32'(illegal), 32'd1);
            end
            in_valid = 1'b0;
            return;
        end
`endif
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) @(negedge clk);
            check($sformatf("done c%0d ins %h", c, ins), 32'(done), 32'(c == lat));
            check("busy in_ready", 32'(in_ready), 32'd0);
            check("busy illegal", 32'(illegal), 32'd0);
            if (lat > 2 && c == lat - 1) begin
                check($sformatf("alu_ain ins %h", ins), 32'(alu_ain), 32'(a));
                check($sformatf("alu_bin ins %h", ins), 32'(alu_bin), 32'(b));
                check($sformatf("alu_op ins %h", ins), 32'(alu_op), 32'(e_op));
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("retired in_ready", 32'(in_ready), 32'd1);
        check("retired done", 32'(done), 32'd0);
        if (wr && !ill) m_reg[waddr] = wdata;
        m_status = nstat;
        check_state($sformatf("after %h", ins));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Assert reset while an ALU instruction sits in EXEC
    task automatic reset_in_exec(input logic [15:0] ins);
        wait_ready();
        in_valid = 1'b1;
        instr    = ins;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("pre-abort done", 32'(done), 32'd0);
        end
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        check("abort in_ready", 32'(in_ready), 32'd1);
        check("abort done", 32'(done), 32'd0);
        model_clear();
        check_state("abort");
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post-abort done", 32'(done), 32'd0);
            check("post-abort in_ready", 32'(in_ready), 32'd1);
        end
        check_state("post-abort");
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        instr    = '0;
        dbg_addr = '0;
        model_clear();
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset done", 32'(done), 32'd0);
        check_state("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // MOV R0,#-3
        run_instr(f_movi(3'd0, 8'hFD));
        lit_reg("lit R0", 3'd0, 16'hFFFD);
        check("lit status0", 32'(status), 32'h0);

        // MOV R1,#5; MOV R2,#3; ADD R3,R1,R2 LSL1
        run_instr(f_movi(3'd1, 8'd5));
        run_instr(f_movi(3'd2, 8'd3));
        run_instr(f_alu(2'b00, 3'd1, 3'd3, 2'b01, 3'd2));
        lit_reg("lit R3", 3'd3, 16'd11);
        check("lit status add", 32'(status), 32'h0);

        // CMP R2,R1 then MVN R5,R0
        run_instr(f_alu(2'b01, 3'd2, 3'd0, 2'b00, 3'd1));
        @(negedge clk);
        check("lit status cmp", 32'(status), 32'b010);
        lit_reg("lit R0 after cmp", 3'd0, 16'hFFFD);
        run_instr(f_alu(2'b11, 3'd0, 3'd5, 2'b00, 3'd0));
        lit_reg("lit R5", 3'd5, 16'h0002);

        // MOV R6,R0 ASR1
        run_instr(f_movr(3'd6, 2'b11, 3'd0));
        lit_reg("lit R6", 3'd6, 16'hFFFE);

        // Reset during EXEC of ADD R7,R1,R2
        reset_in_exec(f_alu(2'b00, 3'd1, 3'd7, 2'b00, 3'd2));

        // Illegal opcode 111
        run_instr(f_movi(3'd1, 8'd7));
        run_instr(16'hE123);
`ifdef EXEC_CTRL_ILLEGAL_TRAP_EN
        do_reset();
        check_state("post-trap reset");
`else
        lit_reg("lit R1 after illegal", 3'd1, 16'd7);
`endif

        // Randomized stream
        for (int n = 0; n < 400; n++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            run_instr(rand_instr());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning datapath and register width.
REQ-002 SHALL have parameter NREG, default 8, meaning register-file depth; addressed by 3-bit fields.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  instruction offered.
REQ-006 SHALL have port in_ready  output  1  block can accept an instruction.
REQ-007 SHALL have port instr  input  16  instruction word: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] shift, [2:0] Rm, [7:0] imm8.
REQ-008 SHALL have port alu_ain  output  DATA_W  ALU A operand.
REQ-009 SHALL have port alu_bin  output  DATA_W  ALU B operand.
REQ-010 SHALL have port alu_op  output  2  ALU operation: 00 add, 01 sub, 10 and, 11 not-B.
REQ-011 SHALL have port alu_out  input  DATA_W  ALU result.
REQ-012 SHALL have port alu_z  input  3  ALU flags: [0] zero, [1] negative, [2] overflow.
REQ-013 SHALL have port status  output  3  registered flags, same bit order as alu_z.
REQ-014 SHALL have port done  output  1  one-cycle pulse when an instruction retires.
REQ-015 SHALL have port illegal  output  1  illegal-opcode indication.
REQ-016 SHALL have port dbg_addr  input  3  debug register select.
REQ-017 SHALL have port dbg_data  output  DATA_W  combinational read of R[dbg_addr].

Function
REQ-018 SHALL drive in_ready high only in state IDLE; an instruction is accepted when in_valid and in_ready are both high at a rising edge; instr is latched then and is ignored at all other times.
REQ-019 SHALL decode: 110/10 MOV Rn,#sx(imm8); 110/00 MOV Rd,sh(Rm); 101/00 ADD Rd=Rn+sh(Rm); 101/01 CMP Rn-sh(Rm); 101/10 AND Rd=Rn&sh(Rm); 101/11 MVN Rd=~sh(Rm); every other opcode/op is illegal.
REQ-020 SHALL apply sh: 00 none, 01 shift left 1 with zero fill, 10 logical shift right 1, 11 arithmetic shift right 1.
REQ-021 SHALL sequence states IDLE -> DECODE -> {WRITE for MOV-imm | LOAD_B for MOV-reg | LOAD_A for ALU class} ; LOAD_A -> LOAD_B -> EXEC -> WRITE -> IDLE.
REQ-022 SHALL load A<=R[Rn] in LOAD_A and B<=R[Rm] in LOAD_B.
REQ-023 SHALL in EXEC drive alu_ain=A (0 for MOV-reg), alu_bin=sh(B), alu_op=op (00 for MOV-reg), latch C<=alu_out, and latch status<=alu_z only for CMP.
REQ-024 SHALL in WRITE write C (or sx(imm8) to Rn for MOV-imm) to Rd; CMP writes no register; done pulses in WRITE.
REQ-025 SHALL retire MOV-imm 2 cycles, MOV-reg 4 cycles, ALU class 5 cycles after the accepting edge; in_ready returns high the cycle after done.
REQ-026 SHALL make a WRITE visible to the next instruction's LOAD_A/LOAD_B and to dbg_data the cycle after WRITE.
REQ-027 SHALL hold alu_ain/alu_bin/alu_op at their register-derived values outside EXEC; the ALU result is sampled only in EXEC.

Reset
REQ-028 SHALL on reset_n low immediately force state IDLE, all registers R0-R7, A, B, C to 0, status 000, done 0, illegal 0.
REQ-029 SHALL abort an in-flight instruction on reset with no register write and no done pulse.

Configuration
REQ-030 SHALL, with EXEC_CTRL_ILLEGAL_TRAP_EN defined, on an illegal instruction set illegal sticky high, pulse no done, and stay in a HALT state with in_ready low until reset.
REQ-031 SHALL, without EXEC_CTRL_ILLEGAL_TRAP_EN, treat an illegal instruction as NOP: DECODE -> WRITE, no register or status change, done pulses, illegal stays 0.

Structure
REQ-032 SHALL place opcode/op constants, shift codes, ALU op codes (00 add, 01 sub, 10 and, 11 not) and the state enum in package exec_ctrl_pkg.
REQ-033 SHALL instantiate sub-module exec_regfile (NREG x DATA_W, one synchronous write port, two combinational read ports: operand and debug).

Verification
REQ-034 SHALL cover: reset, MOV R0,#-3 -> done 2 cycles after accept, R0=16'hFFFD, status 000.
REQ-035 SHALL cover: MOV R1,#5; MOV R2,#3; ADD R3,R1,R2 LSL1 -> R3=11 after 5 cycles, status unchanged.
REQ-036 SHALL cover: CMP R2,R1 (3-5) -> status=3'b010, no register changes; MVN R5,R0 -> R5=16'h0002.
REQ-037 SHALL cover: in_valid held high while busy -> in_ready 0, only one acceptance per instruction; reset_n low during EXEC -> no write, no done, IDLE.
REQ-038 SHALL cover: instr opcode 111 -> with macro illegal=1 and in_ready stays 0; without macro done pulses, registers unchanged.
